uart_alu_controller: RTL and testbench

//  Sequencer between UART rx, ALU and UART tx. Collects three received words
//  (operand A, operand B, opcode), drives them to the ALU, captures the

---
 rtl/uart_alu_controller.sv | 189 ++++++++++++++++++
 tb/tb_uart_alu_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_controller.sv
// uart_alu_controller
// Sequences UART rx -> ALU -> UART tx. Collects operand A, operand B and an
// opcode from three received words. Drives them to the ALU, captures the
// result and launches it through tx. A frame left incomplete for too long
// between words is aborted.
module uart_alu_controller #(
    parameter int WIDTH_WORD      = 8,
    parameter int CANT_BIT_OPCODE = 6,
    parameter int TIMEOUT_CYCLES  = 100000
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_rx_done,
    input  logic [WIDTH_WORD-1:0]      i_data_rx,
    input  logic [WIDTH_WORD-1:0]      i_alu_result,
    input  logic                       i_tx_done,
    output logic [WIDTH_WORD-1:0]      o_alu_data_a,
    output logic [WIDTH_WORD-1:0]      o_alu_data_b,
    output logic [CANT_BIT_OPCODE-1:0] o_alu_opcode,
    output logic                       o_tx_start,
    output logic [WIDTH_WORD-1:0]      o_data_tx,
    output logic                       o_busy,
    output logic                       o_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                       r_rx_prev;
    logic                       r_tx_prev;
    logic [CNT_W-1:0]           r_tmo_cnt;
    logic [WIDTH_WORD-1:0]      r_alu_a;
    logic [WIDTH_WORD-1:0]      r_alu_b;
    logic [CANT_BIT_OPCODE-1:0] r_alu_op;
    logic [WIDTH_WORD-1:0]      r_data_tx;
    logic                       r_tx_start;
    logic                       r_timeout;

    logic w_rx_edge;
    logic w_tx_edge;
    logic w_cap_a;
    logic w_cap_b;
    logic w_cap_op;
    logic w_load_tx;
    logic w_start;
    logic w_tmo;
    logic w_cnt_run;

    // A level held for several cycles must count as a single event.
    assign w_rx_edge = i_rx_done & ~r_rx_prev;
    assign w_tx_edge = i_tx_done & ~r_tx_prev;

    // Previous-sample registers for edge detection
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rx_prev <= 1'b0;
            r_tx_prev <= 1'b0;
        end else begin
            r_rx_prev <= i_rx_done;
            r_tx_prev <= i_tx_done;
        end
    end

    // State register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath enables; an rx edge beats the timeout on the same cycle
    always_comb begin
        w_state_next = r_state;
        w_cap_a      = 1'b0;
        w_cap_b      = 1'b0;
        w_cap_op     = 1'b0;
        w_load_tx    = 1'b0;
        w_start      = 1'b0;
        w_tmo        = 1'b0;
        w_cnt_run    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_rx_edge) begin
                    w_cap_a      = 1'b1;
                    w_state_next = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (w_rx_edge) begin
                    w_cap_b      = 1'b1;
                    w_state_next = ST_WAIT_OP;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_tmo        = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_run    = 1'b1;
                end
            end
            ST_WAIT_OP: begin
                if (w_rx_edge) begin
                    w_cap_op     = 1'b1;
                    w_state_next = ST_EXEC;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_tmo        = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_run    = 1'b1;
                end
            end
            ST_EXEC: begin
                w_load_tx    = 1'b1;
                w_state_next = ST_SEND;
            end
            ST_SEND: begin
                w_start      = 1'b1;
                w_state_next = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (w_tx_edge) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Inter-word timeout counter; runs only while waiting for B or the opcode
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_tmo_cnt <= '0;
        end else if (w_cnt_run) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    // Operand/opcode capture; values survive an abort until overwritten
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
        end else begin
            if (w_cap_a)  r_alu_a  <= i_data_rx;
            if (w_cap_b)  r_alu_b  <= i_data_rx;
            if (w_cap_op) r_alu_op <= i_data_rx[CANT_BIT_OPCODE-1:0];
        end
    end

    // Result capture and single-cycle tx launch / timeout pulses
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_data_tx  <= '0;
            r_tx_start <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_load_tx) r_data_tx <= i_alu_result;
            r_tx_start <= w_start;
            r_timeout  <= w_tmo;
        end
    end

    assign o_alu_data_a = r_alu_a;
    assign o_alu_data_b = r_alu_b;
    assign o_alu_opcode = r_alu_op;
    assign o_data_tx    = r_data_tx;
    assign o_tx_start   = r_tx_start;
    assign o_timeout    = r_timeout;
    assign o_busy       = (r_state == ST_EXEC) || (r_state == ST_SEND) ||
                          (r_state == ST_WAIT_TX);

endmodule

// File: tb/tb_uart_alu_controller.sv
// Directed testbench for uart_alu_controller (TIMEOUT_CYCLES = 100).
module tb_uart_alu_controller;

    localparam int W  = 8;
    localparam int OW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_done = 1'b0;
    logic [W-1:0]  data_rx = '0;
    logic [W-1:0]  alu_result;
    logic          tx_done = 1'b0;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [OW-1:0] alu_op;
    logic          tx_start;
    logic [W-1:0]  data_tx;
    logic          busy;
    logic          timeout;

    int nchk  = 0;
    int npass = 0;

    // Simple ALU stand-in: adds the operands
    assign alu_result = alu_a + alu_b;

    uart_alu_controller #(
        .WIDTH_WORD(W),
        .CANT_BIT_OPCODE(OW),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_rx_done(rx_done),
        .i_data_rx(data_rx),
        .i_alu_result(alu_result),
        .i_tx_done(tx_done),
        .o_alu_data_a(alu_a),
        .o_alu_data_b(alu_b),
        .o_alu_opcode(alu_op),
        .o_tx_start(tx_start),
        .o_data_tx(data_tx),
        .o_busy(busy),
        .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Present a word for 'hold' cycles, then one low cycle before returning
    task automatic send_word(input logic [W-1:0] d, input int hold);
        data_rx = d;
        rx_done = 1'b1;
        repeat (hold) tick();
        rx_done = 1'b0;
        tick();
    endtask

    // Called right after the opcode word; checks result load and launch timing
    task automatic launch(input string tag, input logic [W-1:0] exp_tx);
        check({tag, "_busy_send"}, busy, 1);
        check({tag, "_start_early"}, tx_start, 0);
        check({tag, "_data_tx"}, data_tx, exp_tx);
        tick();
        check({tag, "_start_pulse"}, tx_start, 1);
        tick();
        check({tag, "_start_end"}, tx_start, 0);
        check({tag, "_busy_wait"}, busy, 1);
    endtask

    task automatic tx_finish(input string tag);
        tx_done = 1'b1;
        tick();
        check({tag, "_idle_after_tx"}, busy, 0);
        tick();
        tick();
        tx_done = 1'b0;
        tick();
        check({tag, "_still_idle"}, busy, 0);
    endtask

    initial begin
        // Power-up reset
        tick();
        tick();
        check("rst_a", alu_a, 0);
        check("rst_b", alu_b, 0);
        check("rst_op", alu_op, 0);
        check("rst_tx", data_tx, 0);
        check("rst_start", tx_start, 0);
        check("rst_busy", busy, 0);
        check("rst_tmo", timeout, 0);
        rst = 1'b0;
        tick();

        // T1: reset in the middle of a frame
        send_word(8'hA1, 1);
        send_word(8'hB2, 1);
        check("t1_a_pre", alu_a, 8'hA1);
        check("t1_b_pre", alu_b, 8'hB2);
        #2;
        rst = 1'b1;
        #1;
        check("t1_a_async", alu_a, 0);
        check("t1_b_async", alu_b, 0);
        check("t1_busy_async", busy, 0);
        tick();
        rst = 1'b0;
        tick();

        // T2: basic frame, opcode 0x20, ALU returns 0x08
        send_word(8'h05, 1);
        send_word(8'h03, 1);
        send_word(8'h20, 1);
        check("t2_a", alu_a, 8'h05);
        check("t2_b", alu_b, 8'h03);
        check("t2_op", alu_op, 6'h20);
        launch("t2", 8'h08);
        tx_finish("t2");
        check("t2_tx_hold", data_tx, 8'h08);

        // T3: long rx_done levels count once each
        send_word(8'h05, 16);
        send_word(8'h03, 16);
        check("t3_busy_mid", busy, 0);
        send_word(8'h20, 16);
        check("t3_a", alu_a, 8'h05);
        check("t3_b", alu_b, 8'h03);
        check("t3_op", alu_op, 6'h20);
        check("t3_busy", busy, 1);
        tx_finish("t3");

        // T4: timeout after one word, then a fresh frame
        send_word(8'h11, 1);
        repeat (98) tick();
        check("t4_no_tmo_yet", timeout, 0);
        tick();
        check("t4_tmo_pulse", timeout, 1);
        tick();
        check("t4_tmo_end", timeout, 0);
        check("t4_a_kept", alu_a, 8'h11);
        send_word(8'h22, 1);
        send_word(8'h33, 1);
        send_word(8'h20, 1);
        check("t4_a", alu_a, 8'h22);
        check("t4_b", alu_b, 8'h33);
        launch("t4", 8'h55);

        // T5: word during WAIT_TX is dropped
        send_word(8'h7F, 1);
        check("t5_busy", busy, 1);
        check("t5_a_kept", alu_a, 8'h22);
        check("t5_b_kept", alu_b, 8'h33);
        tx_finish("t5");
        send_word(8'h01, 1);
        send_word(8'h02, 1);
        send_word(8'h03, 1);
        check("t5_a", alu_a, 8'h01);
        check("t5_b", alu_b, 8'h02);
        check("t5_op", alu_op, 6'h03);
        launch("t5", 8'h03);
        tx_finish("t5b");

        // T6: rx edge on the exact timeout cycle wins; opcode truncated to 6 bits
        send_word(8'h44, 1);
        repeat (98) tick();
        data_rx = 8'h55;
        rx_done = 1'b1;
        tick();
        check("t6_no_tmo", timeout, 0);
        check("t6_b", alu_b, 8'h55);
        rx_done = 1'b0;
        tick();
        check("t6_no_tmo2", timeout, 0);
        send_word(8'hC1, 1);
        check("t6_a", alu_a, 8'h44);
        check("t6_op", alu_op, 6'h01);
        launch("t6", 8'h99);
        tx_finish("t6");

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
